// File: rtl/bus_mux_arb.sv
// Registered N-source bus multiplexer with selectable priority, idle hold/zero,
// one-hot violation detection, a sticky conflict flag and a saturating conflict counter.
module bus_mux_arb #(
    parameter int WIDTH     = 32,
    parameter int N         = 24,
    parameter int PRI_HIGH  = 1,
    parameter int HOLD_IDLE = 1,
    parameter int CNT_W     = 8
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic [N*WIDTH-1:0]         bus_in,
    input  logic [N-1:0]               out_en,
    input  logic                       conflict_clr,
    output logic [WIDTH-1:0]           bus_out,
    output logic                       bus_valid,
    output logic [((N>1)?$clog2(N):1)-1:0] src_idx,
    output logic                       conflict,
    output logic                       conflict_sticky,
    output logic [CNT_W-1:0]           conflict_count
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [WIDTH-1:0] bus_q, bus_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             conf_q, conf_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0] win_idx;
    logic [WIDTH-1:0] win_data;
    logic             any_en;
    logic             multi_en;

    // Later loop iterations overwrite earlier ones, so scan order sets priority.
    always_comb begin
        win_idx = '0;
        if (PRI_HIGH != 0) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (out_en[k]) win_idx = IDX_W'(k);
            end
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                if (out_en[N-1-k]) win_idx = IDX_W'(N-1-k);
            end
        end
    end

    assign win_data = bus_in[int'(win_idx)*WIDTH +: WIDTH];
    assign any_en   = |out_en;
    assign multi_en = |(out_en & (out_en - N'(1)));

    always_comb begin
        bus_d    = bus_q;
        valid_d  = 1'b0;
        idx_d    = idx_q;
        conf_d   = multi_en;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;

        if (any_en) begin
            bus_d   = win_data;
            idx_d   = win_idx;
            valid_d = 1'b1;
        end else if (HOLD_IDLE == 0) begin
            bus_d = '0;
        end

        // A conflict on the same edge as conflict_clr restarts the count at one.
        if (multi_en) begin
            sticky_d = 1'b1;
            if (conflict_clr)
                cnt_d = CNT_W'(1);
            else if (cnt_q != '1)
                cnt_d = cnt_q + CNT_W'(1);
        end else if (conflict_clr) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            bus_q    <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            conf_q   <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            bus_q    <= bus_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            conf_q   <= conf_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus_out         = bus_q;
    assign bus_valid       = valid_q;
    assign src_idx         = idx_q;
    assign conflict        = conf_q;
    assign conflict_sticky = sticky_q;
    assign conflict_count  = cnt_q;

endmodule

// File: tb/tb_bus_mux_arb.sv
// Scoreboard bench for bus_mux_arb: two instances (high-priority/hold/8-bit count and
// low-priority/zero-idle/2-bit count) share stimulus and are checked against a reference model.
module tb_bus_mux_arb;

    localparam int W = 32;
    localparam int NS = 24;

    typedef struct packed {
        logic [31:0] bus;
        logic        valid;
        logic [4:0]  idx;
        logic        conf;
        logic        sticky;
        logic [7:0]  cnt;
    } obs_t;

    logic              clock = 1'b0;
    logic              clear = 1'b1;
    logic [NS*W-1:0]   bus_in = '0;
    logic [NS-1:0]     out_en = '0;
    logic              conflict_clr = 1'b0;

    logic [W-1:0] bus_out_a, bus_out_b;
    logic         valid_a, valid_b;
    logic [4:0]   idx_a, idx_b;
    logic         conf_a, conf_b;
    logic         sticky_a, sticky_b;
    logic [7:0]   cnt_a;
    logic [1:0]   cnt_b;

    bus_mux_arb #(.WIDTH(W), .N(NS), .PRI_HIGH(1), .HOLD_IDLE(1), .CNT_W(8)) dut_a (
        .clock(clock), .clear(clear), .bus_in(bus_in), .out_en(out_en),
        .conflict_clr(conflict_clr), .bus_out(bus_out_a), .bus_valid(valid_a),
        .src_idx(idx_a), .conflict(conf_a), .conflict_sticky(sticky_a),
        .conflict_count(cnt_a));

    bus_mux_arb #(.WIDTH(W), .N(NS), .PRI_HIGH(0), .HOLD_IDLE(0), .CNT_W(2)) dut_b (
        .clock(clock), .clear(clear), .bus_in(bus_in), .out_en(out_en),
        .conflict_clr(conflict_clr), .bus_out(bus_out_b), .bus_valid(valid_b),
        .src_idx(idx_b), .conflict(conf_b), .conflict_sticky(sticky_b),
        .conflict_count(cnt_b));

    always #5 clock = ~clock;

    obs_t q_a[$];
    obs_t q_b[$];
    obs_t m[2];
    int   n_checks = 0;
    int   n_pass = 0;

    function automatic obs_t act_a();
        return '{bus: bus_out_a, valid: valid_a, idx: idx_a, conf: conf_a,
                 sticky: sticky_a, cnt: cnt_a};
    endfunction

    function automatic obs_t act_b();
        return '{bus: bus_out_b, valid: valid_b, idx: idx_b, conf: conf_b,
                 sticky: sticky_b, cnt: {6'b0, cnt_b}};
    endfunction

    function automatic void check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: actual bus=%h valid=%b idx=%0d conf=%b sticky=%b cnt=%0d, required bus=%h valid=%b idx=%0d conf=%b sticky=%b cnt=%0d",
                      name, $time, act.bus, act.valid, act.idx, act.conf, act.sticky, act.cnt,
                      exp.bus, exp.valid, exp.idx, exp.conf, exp.sticky, exp.cnt);
    endfunction

    // Reference model: u=0 is highest-wins/hold/max 255, u=1 is lowest-wins/zero/max 3.
    function automatic obs_t model_step(input obs_t s, input int u, input logic clr,
                                        input logic [NS-1:0] en, input logic [NS*W-1:0] d,
                                        input logic cclr);
        obs_t n;
        int   c;
        int   w;
        int   cmax;
        bit   pri_high;
        bit   hold;
        pri_high = (u == 0);
        hold     = (u == 0);
        cmax     = (u == 0) ? 255 : 3;
        n = s;
        if (clr) return '0;
        c = $countones(en);
        w = -1;
        for (int k = 0; k < NS; k++)
            if (en[k] && (pri_high || w < 0)) w = k;
        if (c > 0) begin
            n.bus   = d[w*W +: W];
            n.idx   = 5'(w);
            n.valid = 1'b1;
        end else begin
            n.valid = 1'b0;
            if (!hold) n.bus = '0;
        end
        n.conf = (c >= 2);
        if (c >= 2) begin
            n.sticky = 1'b1;
            n.cnt    = cclr ? 8'd1 : ((int'(s.cnt) >= cmax) ? 8'(cmax) : s.cnt + 8'd1);
        end else if (cclr) begin
            n.sticky = 1'b0;
            n.cnt    = '0;
        end
        return n;
    endfunction

    task automatic cyc(input logic clr, input logic [NS-1:0] en, input logic cclr,
                       input logic [NS*W-1:0] d);
        logic was_clear;
        @(negedge clock);
        was_clear    = clear;
        clear        = clr;
        out_en       = en;
        conflict_clr = cclr;
        bus_in       = d;
        if (clr && !was_clear) begin
            #1;
            check("async_clear_a", act_a(), '0);
            check("async_clear_b", act_b(), '0);
        end
        m[0] = model_step(m[0], 0, clr, en, d, cclr);
        m[1] = model_step(m[1], 1, clr, en, d, cclr);
        q_a.push_back(m[0]);
        q_b.push_back(m[1]);
    endtask

    function automatic logic [NS*W-1:0] rnd_data();
        logic [NS*W-1:0] d;
        for (int k = 0; k < NS; k++) d[k*W +: W] = $urandom;
        return d;
    endfunction

    // Monitor: every output register updates each edge, so one expectation per edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (q_a.size() > 0) check("dut_a", act_a(), q_a.pop_front());
            if (q_b.size() > 0) check("dut_b", act_b(), q_b.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NS*W-1:0] d;
        logic [NS-1:0]   en;
        logic [NS-1:0]   two_hot;
        int              r;
        m[0] = '0;
        m[1] = '0;
        d = rnd_data();

        cyc(1'b1, '0, 1'b0, d);
        cyc(1'b1, '0, 1'b0, d);

        d[3*W +: W] = 32'h3333_3333;
        cyc(1'b0, NS'(1) << 3, 1'b0, d);
        cyc(1'b0, NS'(1) << 3, 1'b0, d);
        cyc(1'b1, NS'(1) << 3, 1'b0, d);
        cyc(1'b0, NS'(1) << 3, 1'b0, d);

        d[5*W +: W] = 32'hDEAD_BEEF;
        cyc(1'b0, NS'(1) << 5, 1'b0, d);
        cyc(1'b0, '0, 1'b0, d);
        cyc(1'b0, '0, 1'b0, d);

        d[2*W +: W] = 32'h11;
        d[9*W +: W] = 32'h99;
        two_hot = (NS'(1) << 2) | (NS'(1) << 9);
        cyc(1'b0, two_hot, 1'b0, d);
        cyc(1'b0, '0, 1'b0, d);

        repeat (5) cyc(1'b0, two_hot, 1'b0, d);
        cyc(1'b0, two_hot, 1'b1, d);
        cyc(1'b0, NS'(1) << 4, 1'b1, d);

        for (int k = 0; k < NS; k++) d[k*W +: W] = 32'(k) * 32'h0101_0101;
        for (int k = 0; k < NS; k++) cyc(1'b0, NS'(1) << k, 1'b0, d);
        cyc(1'b0, NS'(1) << (NS-1), 1'b0, d);

        repeat (400) begin
            d = rnd_data();
            r = $urandom_range(0, 9);
            if (r <= 2) en = '0;
            else if (r <= 6) en = NS'(1) << $urandom_range(0, NS-1);
            else en = NS'($urandom);
            cyc(($urandom_range(0, 49) == 0), en, ($urandom_range(0, 7) == 0), d);
        end
        cyc(1'b0, '0, 1'b0, d);

        repeat (3) @(posedge clock);
        #2;
        n_checks++;
        if (q_a.size() == 0 && q_b.size() == 0) n_pass++;
        else $display("FAIL drain: actual pending=%0d/%0d, required 0/0", q_a.size(), q_b.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_mux_arb.md
Name: bus_mux_arb

Overview:
- Parametrised successor to the datapath bus multiplexer: N sources of WIDTH bits each drive one shared bus through one-hot out-enables.
- Output is registered; there is no combinational path from enables to bus_out.
- Adds selectable priority, idle hold/zero mode, one-hot violation (bus conflict) detection, a sticky error flag and a saturating conflict counter for debug.
- Sits between register-file/special-register outputs and every bus consumer (ALU, Y, MAR, MDR).

Parameters:
- WIDTH, 32, bit width of each source and of the bus.
- N, 24, number of sources; legal range 2..64.
- PRI_HIGH, 1, 1 = highest-index asserted enable wins; 0 = lowest-index wins.
- HOLD_IDLE, 1, 1 = bus keeps its last value when no enable is set; 0 = bus goes to 0.
- CNT_W, 8, width of the conflict counter.

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous active-high reset
- bus_in  in  N*WIDTH  flattened sources; source k is bits [k*WIDTH +: WIDTH]
- out_en  in  N  per-source drive enables (intended one-hot)
- conflict_clr  in  1  synchronous clear of conflict_sticky and conflict_count
- bus_out  out  WIDTH  registered bus value
- bus_valid  out  1  1 when bus_out was loaded from a source in the previous cycle
- src_idx  out  clog2(N)  index of the source captured in bus_out
- conflict  out  1  one-cycle pulse: more than one enable was set last cycle
- conflict_sticky  out  1  latched conflict indicator
- conflict_count  out  CNT_W  number of conflict cycles, saturating

Behaviour:
- Reset (clear=1, asynchronous, any time): bus_out=0, bus_valid=0, src_idx=0, conflict=0, conflict_sticky=0, conflict_count=0. Reset mid-transfer discards the captured value. First capture happens on the first rising edge after clear deasserts.
- Latency: exactly 1 cycle. Enables and data sampled at edge t appear on bus_out after edge t.
- Winner selection, combinational on out_en:
  - PRI_HIGH=1: highest set index wins.
  - PRI_HIGH=0: lowest set index wins.
- Each edge, when any out_en bit is set: bus_out <= bus_in[winner], src_idx <= winner, bus_valid <= 1.
- Each edge, when out_en==0: bus_valid <= 0 and src_idx holds.
  - HOLD_IDLE=1: bus_out holds its previous value.
  - HOLD_IDLE=0: bus_out <= 0.
- Conflict: popcount(out_en) >= 2 at an edge sets the following:
  - conflict <= 1 for one cycle.
  - conflict_sticky <= 1.
  - conflict_count <= conflict_count+1, saturating at 2^CNT_W-1 with no wrap.
  - The winner is still driven normally.
- Otherwise conflict <= 0.
- conflict_clr=1 at an edge with no conflict: sticky <= 0, count <= 0.
- conflict_clr=1 and a conflict at the same edge: the conflict wins. Sticky <= 1, count <= 1, conflict pulses.
- Consecutive conflict cycles count once per cycle. conflict stays high for each such cycle.
- No internal state other than the output registers and the counter. The block needs no FSM beyond these registers; the idle/driving distinction is carried by bus_valid.
- All widths are fixed by parameters. src_idx width is clog2(N), with a minimum of 1.

Test Plan:
- Reset: assert clear asynchronously mid-cycle with out_en=1<<3 active -> all outputs go 0 immediately without waiting for an edge. After release, next edge: bus_out=source3 data, src_idx=3, bus_valid=1.
- Single driver: source 5=0xDEADBEEF, out_en=1<<5 for one cycle, then 0 -> bus_out=0xDEADBEEF one cycle later and holds (HOLD_IDLE=1), bus_valid 1 then 0, conflict stays 0. Repeat with HOLD_IDLE=0 -> bus_out returns to 0.
- Priority: source 2=0x11, source 9=0x99, out_en=(1<<2)|(1<<9) -> bus_out=0x99, src_idx=9 with PRI_HIGH=1. With PRI_HIGH=0 -> 0x11, src_idx=2. Both cases: conflict pulses 1 cycle, sticky=1, count=1.
- Saturation: CNT_W=2, apply a two-hot enable for 5 consecutive cycles -> count goes 1,2,3,3,3; conflict stays high for 5 cycles.
- Clear collision: count=3, then conflict_clr=1 alongside a two-hot enable -> sticky=1, count=1. Next cycle: conflict_clr=1 with one-hot enable -> sticky=0, count=0.
- Sweep: N=24, walk one-hot out_en across all 24 sources with source k=k*0x01010101 -> bus_out and src_idx track each source with 1-cycle latency, no conflict.
